// File: rtl/ndro_seq_pkg.sv
// Shared op codes and FSM encoding for the NDRO pulse sequencer.
package ndro_seq_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_SET   = 2'b01,
      OP_RESET = 2'b10,
      OP_READ  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GAP   = 2'b01,
      PULSE = 2'b10,
      WIN   = 2'b11
   } state_e;

   function automatic logic is_write(input op_e op);
      return (op == OP_SET) || (op == OP_RESET);
   endfunction

endpackage

// File: rtl/sfq_gap_counter.sv
// Saturating cycle counter used to time spacing between cell pulses.
module sfq_gap_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   output logic [CNT_W-1:0] value
);

   // Reset loads the saturated value so the first command after reset never waits.
   always_ff @(posedge clk) begin
      if (!reset_n)
         value <= '1;
      else if (clear)
         value <= '0;
      else if (value != '1)
         value <= value + 1'b1;
   end

endmodule

// File: rtl/ndro_pulse_sequencer.sv
// Turns handshaked SET/RESET/READ commands into spaced single-cycle pulses for one
// NDRO cell, tracks the expected cell state and returns captured read data.
module ndro_pulse_sequencer
   import ndro_seq_pkg::*;
#(
   parameter int SR_GAP   = 4,
   parameter int CLK_GAP  = 6,
   parameter int READ_LAT = 3,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_op,
   output logic       cmd_ready,
   output logic       ndro_set,
   output logic       ndro_reset,
   output logic       ndro_clk,
   input  logic       ndro_out,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_data,
   output logic       rsp_mismatch,
   output logic       model_state,
   output logic       spurious_out
);

   // Counters clear on the decision cycle, so they read 0 during the pulse itself;
   // a pulse decided now lands next cycle, hence the threshold is GAP-1.
   localparam logic [CNT_W-1:0] SR_THR   = CNT_W'(SR_GAP - 1);
   localparam logic [CNT_W-1:0] CLK_THR  = CNT_W'(CLK_GAP - 1);
   localparam int               WIN_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(READ_LAT - 1);

   state_e           state;
   op_e              op_q;
   op_e              next_op;
   logic             launch;
   logic             gap_met;
   logic             fire;
   logic             cmd_fire;
   logic [CNT_W-1:0] pulse_cnt;
   logic [CNT_W-1:0] sr_cnt;
   logic [WIN_W-1:0] win_cnt;
   logic             capture;
   logic             snapshot;
   logic             sample;

   assign cmd_ready = (state == IDLE) && !rsp_valid;
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign sample    = capture | ndro_out;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      next_op = op_q;
      launch  = 1'b0;
      if (state == IDLE) begin
         next_op = op_e'(cmd_op);
         launch  = cmd_fire && (next_op != OP_NOP);
      end else if (state == GAP) begin
         launch  = 1'b1;
      end
      gap_met = (pulse_cnt >= SR_THR) && ((next_op != OP_READ) || (sr_cnt >= CLK_THR));
      fire    = launch && gap_met;
   end

   sfq_gap_counter #(.CNT_W(CNT_W)) u_pulse_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (fire),
      .value   (pulse_cnt)
   );

   sfq_gap_counter #(.CNT_W(CNT_W)) u_sr_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (fire && is_write(next_op)),
      .value   (sr_cnt)
   );

   // NOTE: all state here is updated with non-blocking assignments so every read
   // in this block sees the value from before the clock edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         op_q         <= OP_NOP;
         ndro_set     <= 1'b0;
         ndro_reset   <= 1'b0;
         ndro_clk     <= 1'b0;
         model_state  <= 1'b0;
         snapshot     <= 1'b0;
         capture      <= 1'b0;
         win_cnt      <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= 1'b0;
         rsp_mismatch <= 1'b0;
         spurious_out <= 1'b0;
      end else begin
         ndro_set   <= 1'b0;
         ndro_reset <= 1'b0;
         ndro_clk   <= 1'b0;

         if (ndro_out && (state != WIN))
            spurious_out <= 1'b1;

         if (rsp_valid && rsp_ready) begin
            rsp_valid    <= 1'b0;
            rsp_data     <= 1'b0;
            rsp_mismatch <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (launch) begin
                  op_q  <= next_op;
                  state <= fire ? PULSE : GAP;
               end
            end
            GAP: begin
               if (fire)
                  state <= PULSE;
            end
            PULSE: begin
               if (op_q == OP_READ) begin
                  snapshot <= model_state;
                  capture  <= 1'b0;
                  win_cnt  <= '0;
                  state    <= WIN;
               end else begin
                  state <= IDLE;
               end
            end
            WIN: begin
               capture <= sample;
               if (win_cnt == WIN_LAST) begin
                  rsp_valid    <= 1'b1;
                  rsp_data     <= sample;
                  rsp_mismatch <= sample ^ snapshot;
                  state        <= IDLE;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (fire) begin
            case (next_op)
               OP_SET: begin
                  ndro_set    <= 1'b1;
                  model_state <= 1'b1;
               end
               OP_RESET: begin
                  ndro_reset  <= 1'b1;
                  model_state <= 1'b0;
               end
               OP_READ: ndro_clk <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ndro_pulse_sequencer.sv
// Scoreboard bench for ndro_pulse_sequencer driving a behavioural NDRO cell load.
module tb_ndro_pulse_sequencer;
   import ndro_seq_pkg::*;

   localparam int SR_GAP   = 4;
   localparam int CLK_GAP  = 6;
   localparam int READ_LAT = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic       cmd_ready;
   logic       ndro_set, ndro_reset, ndro_clk;
   logic       ndro_out;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic       rsp_data, rsp_mismatch, model_state, spurious_out;

   ndro_pulse_sequencer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .cmd_valid    (cmd_valid),
      .cmd_op       (cmd_op),
      .cmd_ready    (cmd_ready),
      .ndro_set     (ndro_set),
      .ndro_reset   (ndro_reset),
      .ndro_clk     (ndro_clk),
      .ndro_out     (ndro_out),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_mismatch (rsp_mismatch),
      .model_state  (model_state),
      .spurious_out (spurious_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Cell load: out pulses for one cycle after a clk pulse when the cell holds a 1.
   logic cell_q = 1'b0, cell_pulse_q = 1'b0, force_en = 1'b0, force_val = 1'b0;
   always @(posedge clk) begin
      if (ndro_set) cell_q <= 1'b1;
      else if (ndro_reset) cell_q <= 1'b0;
      cell_pulse_q <= ndro_clk & cell_q;
   end
   assign ndro_out = force_en ? force_val : cell_pulse_q;

   typedef struct { int op; int cyc; int mstate; } pulse_exp_t;
   typedef struct { int data; int mism; int cyc; } rsp_exp_t;
   pulse_exp_t pq[$];
   rsp_exp_t   rq[$];

   int n_tests = 0, n_fail = 0;
   int last_p = -1000, last_sr = -1000;
   int ref_cell = 0, ref_model = 0;
   int force_zero_read = 0;
   int ready_mode = 0;
   int rsp_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: a pulse lands at the earliest cycle meeting every spacing rule.
   task automatic model_accept(input op_e op, input int c);
      int t;
      if (op == OP_NOP) return;
      t = c + 1;
      if (t < last_p + SR_GAP) t = last_p + SR_GAP;
      if (op == OP_READ && t < last_sr + CLK_GAP) t = last_sr + CLK_GAP;
      last_p = t;
      case (op)
         OP_SET: begin
            ref_cell = 1; ref_model = 1; last_sr = t;
            pq.push_back('{1, t, 1});
         end
         OP_RESET: begin
            ref_cell = 0; ref_model = 0; last_sr = t;
            pq.push_back('{2, t, 0});
         end
         default: begin
            int d;
            d = force_zero_read ? 0 : ref_cell;
            pq.push_back('{3, t, ref_model});
            rq.push_back('{d, d ^ ref_model, t + READ_LAT + 1});
         end
      endcase
   endtask

   task automatic send(input op_e op);
      int waited = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      while (!cmd_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         check("cmd_accept_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      model_accept(op, cyc);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
   endtask

   task automatic drain();
      int waited = 0;
      while ((pq.size() != 0 || rq.size() != 0 || rsp_valid) && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 300) begin
         check("drain_timeout", 0, 1);
         pq.delete();
         rq.delete();
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset_n = 1'b0;
      repeat (n) @(negedge clk);
      reset_n = 1'b1;
      pq.delete();
      rq.delete();
      last_p    = -1000;
      last_sr   = -1000;
      ref_model = 0;
      rsp_seen  = 0;
   endtask

   // Monitor: drives rsp_ready for the coming edge, then pops and compares.
   int npulse, act_op;
   pulse_exp_t pe;
   rsp_exp_t   re;
   always @(negedge clk) begin
      case (ready_mode)
         0:       rsp_ready = 1'b1;
         1:       rsp_ready = 1'($urandom_range(0, 1));
         default: rsp_ready = 1'b0;
      endcase

      npulse = int'(ndro_set) + int'(ndro_reset) + int'(ndro_clk);
      if (npulse != 0) begin
         check("pulse_onehot", npulse, 1);
         act_op = ndro_set ? 1 : (ndro_reset ? 2 : 3);
         if (pq.size() == 0) begin
            check("pulse_unexpected_op", act_op, 0);
         end else begin
            pe = pq.pop_front();
            check("pulse_op", act_op, pe.op);
            check("pulse_cycle", cyc, pe.cyc);
            check("pulse_model_state", model_state, pe.mstate);
         end
      end else if (pq.size() != 0 && cyc > pq[0].cyc) begin
         check("pulse_missing_cycle", cyc, pq[0].cyc);
         void'(pq.pop_front());
      end

      if (rsp_valid && rsp_seen == 0) begin
         rsp_seen = 1;
         if (rq.size() == 0) check("rsp_unexpected", 1, 0);
         else check("rsp_cycle", cyc, rq[0].cyc);
      end
      if (rsp_valid && rsp_ready) begin
         rsp_seen = 0;
         if (rq.size() != 0) begin
            re = rq.pop_front();
            check("rsp_data", rsp_data, re.data);
            check("rsp_mismatch", rsp_mismatch, re.mism);
         end
      end else if (!rsp_valid && rq.size() != 0 && cyc > rq[0].cyc) begin
         check("rsp_missing_cycle", cyc, rq[0].cyc);
         void'(rq.pop_front());
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      do_reset(3);
      @(negedge clk);
      check("reset_outputs",
            {ndro_set, ndro_reset, ndro_clk, rsp_valid, rsp_data, rsp_mismatch, model_state, spurious_out}, 0);
      check("reset_cmd_ready", cmd_ready, 1);

      // 1: first SET pulses one cycle after accept
      send(OP_SET);
      drain();
      check("t1_model_state", model_state, 1);

      // 2: back-to-back SETs, spacing enforced by the scoreboard cycle check
      send(OP_SET);
      send(OP_SET);
      drain();
      check("t2_model_state", model_state, 1);
      check("t2_spurious", spurious_out, 0);

      // 3: SET, RESET, READ
      send(OP_SET);
      send(OP_RESET);
      send(OP_READ);
      drain();
      check("t3_model_state", model_state, 0);

      // 4: SET, READ with the response held off for 5 cycles
      ready_mode = 2;
      send(OP_SET);
      send(OP_READ);
      waited = 0;
      while (!rsp_valid && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("t4_rsp_arrived", rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_valid", rsp_valid, 1);
         check("t4_hold_data", rsp_data, 1);
         check("t4_hold_cmd_ready", cmd_ready, 0);
      end
      ready_mode = 0;
      drain();

      // 5: spurious out while idle, then a READ whose out is forced low
      check("t5_spurious_before", spurious_out, 0);
      @(negedge clk);
      force_en  = 1'b1;
      force_val = 1'b1;
      @(negedge clk);
      force_en  = 1'b0;
      check("t5_spurious_set", spurious_out, 1);
      send(OP_SET);
      force_zero_read = 1;
      force_en  = 1'b1;
      force_val = 1'b0;
      send(OP_READ);
      drain();
      force_en = 1'b0;
      force_zero_read = 0;
      check("t5_spurious_sticky", spurious_out, 1);
      do_reset(2);
      @(negedge clk);
      check("t5_spurious_cleared", spurious_out, 0);

      // 6: reset while a READ waits in GAP aborts it
      send(OP_SET);
      send(OP_READ);
      do_reset(2);
      check("t6_outputs", {ndro_set, ndro_reset, ndro_clk, rsp_valid, model_state, spurious_out}, 0);
      repeat (10) @(negedge clk);
      check("t6_no_rsp", rsp_valid, 0);
      send(OP_SET);
      drain();

      // random traffic with random response back-pressure
      ready_mode = 1;
      for (int i = 0; i < 80; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(op_e'($urandom_range(0, 3)));
      end
      drain();
      ready_mode = 0;
      check("rand_spurious", spurious_out, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
